// File: rtl/ifetch_queue.sv
// In-order instruction prefetch queue: issues sequential fetches, buffers responses, flushes on redirect.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in the FAULT state.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4,
  output logic        fault
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;

  typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [CW-1:0] qcount;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [PW-1:0] q_head, q_tail;
  logic [PW-1:0] t_head, t_tail;

  logic [31:0] q_instr  [DEPTH];
  logic [31:0] q_pc     [DEPTH];
  logic [31:0] tag_addr [DEPTH];

  logic           req_fire;
  logic           rsp_live;
  logic           rsp_drop;
  logic           pop;
  logic           misaligned;
  logic [CW1-1:0] credit_used;
  logic [CW-1:0]  discard_after;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = |redirect_pc[1:0];
  assign fault      = (state == FAULT);
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign misaligned     = 1'b0;
  assign fault          = 1'b0;
`endif

  // Every queued entry and every in-flight request holds one slot, so the queue cannot overflow.
  assign credit_used    = {1'b0, qcount} + {1'b0, outstanding};
  assign imem_req_valid = !reset && (state == FETCH) && !redirect && (credit_used < CW1'(DEPTH));
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop      = imem_rsp_valid && (discard != '0);
  assign rsp_live      = imem_rsp_valid && (discard == '0) && (state == FETCH) && !redirect;
  assign pop           = out_valid && out_ready;
  assign discard_after = outstanding - CW'(imem_rsp_valid);

  assign out_valid   = (qcount != '0);
  assign out_instr   = out_valid ? q_instr[q_head] : '0;
  assign out_pc      = out_valid ? q_pc[q_head] : '0;
  assign out_pcplus4 = out_valid ? (q_pc[q_head] + 32'd4) : '0;

  // Control state, fetch PC, counters and queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fpc         <= RESET_PC;
      qcount      <= '0;
      outstanding <= '0;
      discard     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      t_head      <= '0;
      t_tail      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        // A pop in this cycle has already been taken by the core; the flush supersedes it.
        fpc     <= {redirect_pc[31:2], 2'b00};
        discard <= discard_after;
        qcount  <= '0;
        q_head  <= '0;
        q_tail  <= '0;
        t_head  <= '0;
        t_tail  <= '0;
        if (misaligned) begin
          state <= FAULT;
        end else if (discard_after != '0) begin
          state <= DRAIN;
        end else begin
          state <= FETCH;
        end
      end else begin
        if (req_fire) begin
          fpc    <= fpc + 32'd4;
          t_tail <= t_tail + PW'(1);
        end
        if (rsp_live) begin
          q_tail <= q_tail + PW'(1);
          t_head <= t_head + PW'(1);
        end
        if (pop) begin
          q_head <= q_head + PW'(1);
        end
        qcount <= qcount + CW'(rsp_live) - CW'(pop);
        if (rsp_drop) begin
          discard <= discard - CW'(1);
        end
        if ((state == DRAIN) && rsp_drop && (discard == CW'(1))) begin
          state <= FETCH;
        end
      end
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (rsp_live) begin
      q_instr[q_tail] <= imem_rsp_data;
      q_pc[q_tail]    <= tag_addr[t_head];
    end
    if (req_fire) begin
      tag_addr[t_tail] <= fpc;
    end
  end

endmodule
